fsm_cmd_issuer: RTL and testbench

- Command-side counterpart of the 3-bit state controller. It drives the controller's in1/in2 inputs and watches its state output.
- Accepts path commands over a valid/ready handshake and presents them to the controller in the single cycle the controller samples them (state 000).
- Reports completion per command.
- Runs a cycle-accurate shadow model of the controller and flags any state-trace divergence or stall as a sticky error.

---
 rtl/fsm_cmd_issuer_pkg.sv | 37 +++
 rtl/fsm_cmd_issuer_if.sv | 14 +
 rtl/fsm_cmd_issuer_model.sv | 26 ++
 rtl/fsm_cmd_issuer.sv | 116 +++++++++++
 tb/tb_fsm_cmd_issuer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fsm_cmd_issuer_pkg.sv
// Shared definitions for the command issuer and the 3-bit controller it drives:
// state codes, path opcodes and the in1/in2 encoding of each path.
package fsm_proc_pkg;

    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_A1   = 3'b001;
    localparam logic [2:0] ST_A2   = 3'b101;
    localparam logic [2:0] ST_A3   = 3'b010;
    localparam logic [2:0] ST_B1   = 3'b110;
    localparam logic [2:0] ST_B2   = 3'b111;
    localparam logic [2:0] ST_C1   = 3'b011;
    localparam logic [2:0] ST_END  = 3'b100;
    localparam logic [2:0] ST_RST  = 3'b011;

    typedef logic [1:0] op_t;

    localparam op_t OP_A  = 2'd0;
    localparam op_t OP_B  = 2'd1;
    localparam op_t OP_C  = 2'd2;
    localparam op_t OP_A2 = 2'd3;

    typedef struct packed {
        logic vld;
        op_t  op;
    } cmd_slot_t;

    // Returns {in1, in2} for a path opcode.
    function automatic logic [1:0] op_ins(input op_t op);
        case (op)
            OP_B:    return 2'b01;
            OP_C:    return 2'b11;
            OP_A2:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/fsm_cmd_issuer_if.sv
// Command handshake and completion report between a command source and the issuer.
interface fsm_cmd_issuer_if;
    import fsm_proc_pkg::*;

    logic cmd_valid;
    op_t  cmd_op;
    logic cmd_ready;
    logic done;
    op_t  done_op;

    modport master (output cmd_valid, cmd_op, input cmd_ready, done, done_op);
    modport slave  (input cmd_valid, cmd_op, output cmd_ready, done, done_op);

endinterface

// File: rtl/fsm_cmd_issuer_model.sv
// Combinational next-state function of the 3-bit controller; 000 is the only
// state that looks at in1/in2.
module fsm_state_model
    import fsm_proc_pkg::*;
(
    input  logic [2:0] state,
    input  logic       in1,
    input  logic       in2,
    output logic [2:0] state_nxt
);

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: state_nxt = !in2 ? ST_A1 : (in1 ? ST_C1 : ST_B1);
            ST_A1:   state_nxt = ST_A2;
            ST_A2:   state_nxt = ST_A3;
            ST_A3:   state_nxt = ST_END;
            ST_B1:   state_nxt = ST_B2;
            ST_B2:   state_nxt = ST_END;
            ST_C1:   state_nxt = ST_END;
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/fsm_cmd_issuer.sv
// Feeds path commands to the 3-bit controller at its 100 states, reports completion,
// and shadows the controller trace to flag divergence or stalls.
module fsm_cmd_issuer
    import fsm_proc_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int WDOG_CYC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    fsm_cmd_issuer_if.slave  cmd,
    input  logic [2:0]       state_in,
    output logic             in1,
    output logic             in2,
    output logic             err,
    output logic [2:0]       err_state,
    output logic [2:0]       err_exp,
    input  logic             err_clr,
    output logic [CNT_W-1:0] cmd_count
);

    localparam int              WD_W    = $clog2(WDOG_CYC + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_CYC);
    localparam logic [WD_W-1:0] WD_TRIP = WD_W'(WDOG_CYC - 1);

    cmd_slot_t       pending;
    cmd_slot_t       inflight;
    logic            sync;
    logic [WD_W-1:0] wdog;
    logic [2:0]      prev_state;
    logic [2:0]      exp_state;
    logic            done_r;
    op_t             done_op_r;
    logic            at_end;
    logic            finish;
    logic            trace_bad;
    logic            stall;

    // in1/in2 are the values the controller saw on the edge that produced state_in
    fsm_state_model u_model (
        .state     (prev_state),
        .in1       (in1),
        .in2       (in2),
        .state_nxt (exp_state)
    );

    assign cmd.cmd_ready = !pending.vld;
    assign cmd.done      = done_r;
    assign cmd.done_op   = done_op_r;

    always_comb begin
        at_end    = (state_in == ST_END);
        finish    = at_end && inflight.vld;
        trace_bad = sync && (state_in != exp_state);
        stall     = sync && !at_end && (wdog == WD_TRIP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            inflight   <= '0;
            in1        <= 1'b0;
            in2        <= 1'b0;
            done_r     <= 1'b0;
            done_op_r  <= '0;
            cmd_count  <= '0;
            err        <= 1'b0;
            err_state  <= '0;
            err_exp    <= '0;
            sync       <= 1'b0;
            wdog       <= '0;
            prev_state <= '0;
        end else begin
            prev_state <= state_in;
            done_r     <= finish;
            if (finish) begin
                done_op_r <= inflight.op;
                cmd_count <= cmd_count + 1'b1;
            end

            // Every 100 is an issue point; without a command the idle path A is driven.
            if (at_end) begin
                inflight.vld <= 1'b0;
                {in1, in2}   <= 2'b00;
                if (!err && pending.vld) begin
                    {in1, in2}  <= op_ins(pending.op);
                    inflight    <= pending;
                    pending.vld <= 1'b0;
                end
            end

            // Only taken when the slot is empty, so it never collides with the issue above.
            if (cmd.cmd_valid && !pending.vld)
                pending <= '{vld: 1'b1, op: cmd.cmd_op};

            if (err_clr) begin
                err  <= 1'b0;
                sync <= 1'b0;
                wdog <= '0;
            end else begin
                if (at_end)
                    sync <= 1'b1;
                if (at_end)
                    wdog <= '0;
                else if (wdog != WD_MAX)
                    wdog <= wdog + 1'b1;
                if (!err && (trace_bad || stall)) begin
                    err       <= 1'b1;
                    err_state <= state_in;
                    err_exp   <= trace_bad ? exp_state : ST_END;
                end
            end
        end
    end

endmodule

// File: tb/tb_fsm_cmd_issuer.sv
// Closed-loop bench: emulates the controller from path tables and predicts the issuer
// from command latencies, with a second short-watchdog instance for stall timing.
module tb_fsm_cmd_issuer;

    localparam int WDOG   = 8;
    localparam int WDOG_W = 4;

    logic       clk;
    logic       rst_n;
    logic       err_clr;
    logic [2:0] state_in;
    logic       in1, in2, err;
    logic [2:0] err_state, err_exp;
    logic [7:0] cmd_count;
    logic       w_in1, w_in2, w_err;
    logic [2:0] w_err_state, w_err_exp;
    logic [7:0] w_count;

    fsm_cmd_issuer_if cif ();
    fsm_cmd_issuer_if wif ();

    fsm_cmd_issuer #(.CNT_W(8), .WDOG_CYC(WDOG)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cif.slave), .state_in(state_in),
        .in1(in1), .in2(in2), .err(err), .err_state(err_state), .err_exp(err_exp),
        .err_clr(err_clr), .cmd_count(cmd_count)
    );

    fsm_cmd_issuer #(.CNT_W(8), .WDOG_CYC(WDOG_W)) dut_w (
        .clk(clk), .rst_n(rst_n), .cmd(wif.slave), .state_in(state_in),
        .in1(w_in1), .in2(w_in2), .err(w_err), .err_state(w_err_state), .err_exp(w_err_exp),
        .err_clr(1'b0), .cmd_count(w_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    int         n_vec, n_fail, edge_no, m_since, w_since, m_done_at;
    bit         m_pend, m_inf, m_done, m_err, m_sync, w_err_m, w_sync, chk_w;
    logic [1:0] m_pend_op, m_inf_op, m_done_op, m_in;
    logic [2:0] m_prev, m_err_state, m_err_exp, w_st, ctrl_nxt;
    logic [7:0] m_count;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Controller successor: 000 picks a path, 100 returns to 000, others walk their path.
    function automatic logic [2:0] ref_next(input logic [2:0] s, input logic [1:0] inp);
        logic [2:0] walk [3][4];
        walk = '{'{3'b001, 3'b101, 3'b010, 3'b100},
                 '{3'b110, 3'b111, 3'b100, 3'b100},
                 '{3'b011, 3'b100, 3'b100, 3'b100}};
        if (s == 3'b000) return !inp[0] ? 3'b001 : (inp[1] ? 3'b011 : 3'b110);
        if (s == 3'b100) return 3'b000;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 3; i++)
                if (walk[p][i] == s) return walk[p][i+1];
        return 3'b000;
    endfunction

    function automatic int path_len(input logic [1:0] op);
        case (op)
            2'd1:    return 4;
            2'd2:    return 3;
            default: return 5;
        endcase
    endfunction

    function automatic logic [1:0] drive_of(input logic [1:0] op);
        logic [1:0] tbl [4];
        tbl = '{2'b00, 2'b01, 2'b11, 2'b10};
        return tbl[op];
    endfunction

    task automatic model_reset();
        m_pend = 0; m_inf = 0; m_done = 0; m_err = 0; m_sync = 0;
        m_pend_op = 0; m_inf_op = 0; m_done_op = 0; m_in = 0; m_since = 0; m_done_at = -1;
        m_prev = 0; m_err_state = 0; m_err_exp = 0; m_count = 0;
        w_err_m = 0; w_sync = 0; w_since = 0; w_st = 0;
        ctrl_nxt = 3'b011; state_in = 3'b011;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in12"},    8'({in1, in2}),     8'd0);
        chk({tag, "_ready"},   8'(cif.cmd_ready),  8'd1);
        chk({tag, "_done"},    8'(cif.done),       8'd0);
        chk({tag, "_done_op"}, 8'(cif.done_op),    8'd0);
        chk({tag, "_err"},     8'(err),            8'd0);
        chk({tag, "_err_st"},  8'(err_state),      8'd0);
        chk({tag, "_err_exp"}, 8'(err_exp),        8'd0);
        chk({tag, "_count"},   cmd_count,          8'd0);
    endtask

    task automatic tick(input logic v, input logic [1:0] op, input logic clr,
                        input bit frc = 1'b0, input logic [2:0] fst = 3'b000);
        logic [2:0] s, exp_nx;
        logic [1:0] in_pre;
        bit         acc, bad, stall;
        cif.cmd_valid = v;
        cif.cmd_op    = op;
        err_clr       = clr;
        state_in      = frc ? fst : ctrl_nxt;
        s      = state_in;
        in_pre = {in1, in2};
        edge_no++;

        acc    = v && !m_pend;
        exp_nx = ref_next(m_prev, m_in);
        bad    = m_sync && !m_err && (s != exp_nx);
        stall  = m_sync && !m_err && (s != 3'b100) && (m_since + 1 >= WDOG);
        m_done = 0;
        if (m_inf && edge_no == m_done_at) begin
            m_done = 1; m_done_op = m_inf_op; m_count++; m_inf = 0;
        end
        if (s == 3'b100) begin
            if (!m_err && m_pend) begin
                m_in = drive_of(m_pend_op); m_inf = 1; m_inf_op = m_pend_op;
                m_done_at = edge_no + path_len(m_pend_op); m_pend = 0;
            end else
                m_in = 2'b00;
        end
        if (acc) begin m_pend = 1; m_pend_op = op; end
        if (clr) begin
            m_err = 0; m_sync = 0; m_since = 0;
        end else begin
            if (bad || stall) begin
                m_err = 1; m_err_state = s; m_err_exp = bad ? exp_nx : 3'b100;
            end
            if (s == 3'b100) m_sync = 1;
            if (s == 3'b100) m_since = 0; else if (m_since < WDOG) m_since++;
        end
        m_prev = s;

        if (!w_err_m && w_sync && s != 3'b100 && w_since + 1 >= WDOG_W) begin
            w_err_m = 1; w_st = s;
        end
        if (s == 3'b100) begin w_sync = 1; w_since = 0; end
        else if (w_since < WDOG_W) w_since++;

        @(posedge clk);
        @(negedge clk);
        chk("cmd_ready", 8'(cif.cmd_ready), 8'(!m_pend));
        chk("in1_in2",   8'({in1, in2}),    8'(m_in));
        chk("done",      8'(cif.done),      8'(m_done));
        if (m_done) chk("done_op", 8'(cif.done_op), 8'(m_done_op));
        chk("cmd_count", cmd_count, m_count);
        chk("err", 8'(err), 8'(m_err));
        if (m_err) begin
            chk("err_state", 8'(err_state), 8'(m_err_state));
            chk("err_exp",   8'(err_exp),   8'(m_err_exp));
        end
        if (chk_w) begin
            chk("w_err", 8'(w_err), 8'(w_err_m));
            if (w_err_m) begin
                chk("w_err_state", 8'(w_err_state), 8'(w_st));
                chk("w_err_exp",   8'(w_err_exp),   8'd4);
            end
            chk("w_outputs", 8'({w_in1, w_in2, wif.done, wif.done_op, wif.cmd_ready}), 8'd1);
            chk("w_count", w_count, 8'd0);
        end
        ctrl_nxt = ref_next(s, in_pre);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 2'd0, 1'b0);
    endtask

    task automatic offer(input logic [1:0] op);
        bit took = 0;
        for (int k = 0; k < 20 && !took; k++) begin
            took = !m_pend;
            tick(1'b1, op, 1'b0);
        end
        chk("offer_accepted", 8'(took), 8'd1);
    endtask

    task automatic run_until_next(input logic [2:0] st);
        int k = 0;
        while (ctrl_nxt != st && k < 12) begin
            tick(1'b0, 2'd0, 1'b0);
            k++;
        end
        chk("reach_state", 8'(ctrl_nxt), 8'(st));
    endtask

    initial begin
        n_vec = 0; n_fail = 0; edge_no = 0; chk_w = 0;
        rst_n = 1'b0; err_clr = 1'b0;
        cif.cmd_valid = 1'b0; cif.cmd_op = 2'd0;
        wif.cmd_valid = 1'b0; wif.cmd_op = 2'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;

        // Idle trace: filler path only; the 4-cycle watchdog instance trips on the legal 010
        chk_w = 1;
        idle(12);
        chk("w_tripped", 8'(w_err), 8'd1);
        chk("w_trip_state", 8'(w_err_state), 8'b010);
        chk_w = 0;

        // Single path C
        tick(1'b1, 2'd2, 1'b0);
        idle(10);
        chk("count_after_c", cmd_count, 8'd1);

        // B, A, A' offered with valid held
        offer(2'd1);
        offer(2'd0);
        offer(2'd3);
        idle(18);
        chk("count_after_seq", cmd_count, 8'd4);

        // Random command traffic
        for (int k = 0; k < 150; k++)
            tick(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0);
        idle(15);

        // Trace divergence: 110 where 101 is due
        run_until_next(3'b101);
        tick(1'b0, 2'd0, 1'b0, 1'b1, 3'b110);
        chk("inj_err", 8'(err), 8'd1);
        chk("inj_err_state", 8'(err_state), 8'b110);
        chk("inj_err_exp", 8'(err_exp), 8'b101);
        tick(1'b1, 2'd2, 1'b0);
        idle(10);
        chk("inj_held", 8'(cif.cmd_ready), 8'd0);
        tick(1'b0, 2'd0, 1'b1);
        idle(15);
        chk("inj_recovered", 8'(err), 8'd0);

        // Stall at 010
        run_until_next(3'b010);
        tick(1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 9; k++) tick(1'b0, 2'd0, 1'b0, 1'b1, 3'b010);
        chk("stall_err_exp", 8'(err_exp), 8'b100);
        idle(3);
        tick(1'b0, 2'd0, 1'b1);
        idle(10);

        // Reset in the middle of path B
        offer(2'd1);
        for (int k = 0; k < 12 && !m_inf; k++) tick(1'b0, 2'd0, 1'b0);
        chk("b_issued", 8'(m_inf), 8'd1);
        idle(2);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
